// File: rtl/serv_dbus_responder_if.sv
// Wishbone-classic data bus between the SERV core's dbus port (master)
// and the local data-memory responder (slave).
interface serv_dbus_responder_if;
    logic [31:0] i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;
    logic        o_wb_err;

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        input  o_wb_rdt, o_wb_ack, o_wb_err
    );

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc,
        output o_wb_rdt, o_wb_ack, o_wb_err
    );
endinterface

// File: rtl/serv_dbus_responder.sv
// Wishbone-classic data-memory responder for the SERV dbus: byte-addressed
// local RAM, word reads, byte-lane writes, programmable wait states, a
// one-cycle ack/err strobe and an error response for out-of-range addresses.
module serv_dbus_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = $clog2(DEPTH),
    parameter int WAIT_STATES = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    serv_dbus_responder_if.slave bus
);
    localparam int         WORDS = DEPTH / 4;
    localparam int         IW    = AW - 2;
    localparam logic [3:0] WS_L  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    // Access-cycle view: the request fields that take effect on the edge
    // entering RESP (bus inputs directly when there are no wait states).
    logic          acc_s;
    logic [31:0]   acc_adr_s;
    logic [31:0]   acc_dat_s;
    logic [3:0]    acc_sel_s;
    logic          acc_we_s;
    logic          in_range_s;
    logic [IW-1:0] idx_s;
    logic [31:0]   rd_word_s;
    logic          mem_we_s;
    logic          unused_s;

    logic [31:0] mem [WORDS];

    // The initiator always drives the byte offset as 00.
    assign unused_s = ^acc_adr_s[1:0];

    // Next-state logic: request acceptance, wait countdown, abort and response.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        acc_s     = 1'b0;
        acc_adr_s = adr_q;
        acc_dat_s = dat_q;
        acc_sel_s = sel_q;
        acc_we_s  = we_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_wb_cyc) begin
                    adr_d = bus.i_wb_adr;
                    dat_d = bus.i_wb_dat;
                    sel_d = bus.i_wb_sel;
                    we_d  = bus.i_wb_we;
                    cnt_d = WS_L;
                    if (WS_L == 4'd0) begin
                        // Latched copies are not ready yet; use the bus directly.
                        state_d   = S_RESP;
                        acc_s     = 1'b1;
                        acc_adr_s = bus.i_wb_adr;
                        acc_dat_s = bus.i_wb_dat;
                        acc_sel_s = bus.i_wb_sel;
                        acc_we_s  = bus.i_wb_we;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!bus.i_wb_cyc) begin
                    // Initiator withdrew: drop the request silently.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                    acc_s   = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Access decision: range check, read data capture, write enable, strobes.
    always_comb begin
        in_range_s = ((acc_adr_s >> AW) == 32'd0);
        idx_s      = acc_adr_s[AW-1:2];
        rd_word_s  = mem[idx_s];
        ack_d      = 1'b0;
        err_d      = 1'b0;
        rdt_d      = rdt_q;
        mem_we_s   = 1'b0;
        if (acc_s) begin
            if (in_range_s) begin
                ack_d = 1'b1;
                if (acc_we_s) begin
                    // No RAM update while reset is held.
                    mem_we_s = !i_rst;
                end else begin
                    rdt_d = rd_word_s;
                end
            end else begin
                err_d = 1'b1;
                rdt_d = 32'd0;
            end
        end else begin
            ack_d = 1'b0;
        end
    end

    // State, latched request and registered response outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            rdt_q   <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdt_q   <= rdt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane RAM write; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel_s[b]) begin
                    mem[idx_s][8*b +: 8] <= acc_dat_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.o_wb_rdt = rdt_q;
    assign bus.o_wb_ack = ack_q;
    assign bus.o_wb_err = err_q;
endmodule

// File: tb/tb_serv_dbus_responder.sv
// Self-checking bench for serv_dbus_responder: one instance without wait
// states and one with three, checked against a byte-array memory model.
module tb_serv_dbus_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0, rst3;
    serv_dbus_responder_if bus0();
    serv_dbus_responder_if bus3();

    logic [31:0] adr_v [2];
    logic [31:0] dat_v [2];
    logic [3:0]  sel_v [2];
    logic        we_v  [2];
    logic        cyc_v [2];
    logic [31:0] rdt_v [2];
    logic        ack_v [2];
    logic        err_v [2];

    assign bus0.i_wb_adr = adr_v[0];
    assign bus0.i_wb_dat = dat_v[0];
    assign bus0.i_wb_sel = sel_v[0];
    assign bus0.i_wb_we  = we_v[0];
    assign bus0.i_wb_cyc = cyc_v[0];
    assign bus3.i_wb_adr = adr_v[1];
    assign bus3.i_wb_dat = dat_v[1];
    assign bus3.i_wb_sel = sel_v[1];
    assign bus3.i_wb_we  = we_v[1];
    assign bus3.i_wb_cyc = cyc_v[1];
    assign rdt_v[0] = bus0.o_wb_rdt;
    assign ack_v[0] = bus0.o_wb_ack;
    assign err_v[0] = bus0.o_wb_err;
    assign rdt_v[1] = bus3.o_wb_rdt;
    assign ack_v[1] = bus3.o_wb_ack;
    assign err_v[1] = bus3.o_wb_err;

    serv_dbus_responder #(.DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .i_clk (clk),
        .i_rst (rst0),
        .bus   (bus0.slave)
    );

    serv_dbus_responder #(.DEPTH(1024), .WAIT_STATES(3)) u_dut3 (
        .i_clk (clk),
        .i_rst (rst3),
        .bus   (bus3.slave)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: byte memory per instance plus the expected held rdt.
    logic [7:0]  mdl [2][1024];
    logic [31:0] exp_rdt [2];

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] mrd(input int d, input logic [31:0] a);
        logic [31:0] r;
        int base;
        base = int'(a);
        for (int b = 0; b < 4; b++) r[8*b +: 8] = mdl[d][base + b];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One bus transaction; returns the response latency in edges after
    // acceptance (-1 if none within the budget), the err flag and rdt.
    task automatic txn(input int d, input logic [31:0] a, input logic [31:0] dt,
                       input logic [3:0] s, input logic w,
                       output logic [31:0] r, output int lat, output logic e);
        @(negedge clk);
        adr_v[d] = a; dat_v[d] = dt; sel_v[d] = s; we_v[d] = w; cyc_v[d] = 1'b1;
        @(posedge clk);
        lat = -1; e = 1'b0; r = 32'd0;
        for (int j = 0; j < 40; j++) begin
            #1;
            if (ack_v[d] || err_v[d]) begin
                lat = j; e = err_v[d]; r = rdt_v[d];
                chk("strobe_excl", 32'(ack_v[d] & err_v[d]), 32'd0);
                break;
            end
            // Bus changes after acceptance must be ignored.
            adr_v[d] = $urandom; dat_v[d] = $urandom;
            sel_v[d] = 4'($urandom); we_v[d] = ~w;
            @(posedge clk);
        end
        cyc_v[d] = 1'b0;
        @(posedge clk);
        #1;
        chk("strobe_one_cycle", 32'(ack_v[d] | err_v[d]), 32'd0);
        chk("rdt_stable", rdt_v[d], r);
    endtask

    // Transaction checked against the model; the model is then updated.
    task automatic op(input int d, input logic [31:0] a, input logic [31:0] dt,
                      input logic [3:0] s, input logic w, input string tag,
                      output logic [31:0] r);
        int lat;
        logic e;
        logic in_r;
        logic [31:0] expr;
        in_r = (a < 32'd1024);
        if (!in_r)     expr = 32'd0;
        else if (!w)   expr = mrd(d, a);
        else           expr = exp_rdt[d];
        txn(d, a, dt, s, w, r, lat, e);
        chk({tag, "_lat"}, 32'(lat), 32'(ws_of(d)));
        chk({tag, "_err"}, 32'(e), 32'(!in_r));
        chk({tag, "_rdt"}, r, expr);
        exp_rdt[d] = expr;
        if (in_r && w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) mdl[d][int'(a) + b] = dt[8*b +: 8];
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] a;
        logic        any;
        int          k;
        for (int d = 0; d < 2; d++) begin
            adr_v[d] = 32'd0; dat_v[d] = 32'd0; sel_v[d] = 4'd0;
            we_v[d] = 1'b0; cyc_v[d] = 1'b0; exp_rdt[d] = 32'd0;
        end
        rst0 = 1'b1; rst3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_ack", 32'(ack_v[d]), 32'd0);
            chk("reset_err", 32'(err_v[d]), 32'd0);
            chk("reset_rdt", rdt_v[d], 32'd0);
        end
        @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;

        // Basic write/read without wait states.
        op(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, "basic_wr", r);
        op(0, 32'h10, 32'h0, 4'hF, 1'b0, "basic_rd", r);
        chk("basic_value", r, 32'hDEADBEEF);

        // Byte lanes.
        op(0, 32'h20, 32'h11223344, 4'hF, 1'b1, "lane_pre", r);
        op(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, "lane_wr", r);
        op(0, 32'h20, 32'h0, 4'hF, 1'b0, "lane_rd", r);
        chk("lane_value", r, 32'h11BB33DD);
        op(0, 32'h20, 32'h99999999, 4'b0000, 1'b1, "lane_wr0", r);
        op(0, 32'h20, 32'h0, 4'hF, 1'b0, "lane_rd0", r);
        chk("lane0_value", r, 32'h11BB33DD);

        // Out of range.
        op(0, 32'h000, 32'hCAFEF00D, 4'hF, 1'b1, "oor_pre", r);
        op(0, 32'h400, 32'h12345678, 4'hF, 1'b1, "oor_wr", r);
        op(0, 32'h400, 32'h0, 4'hF, 1'b0, "oor_rd", r);
        chk("oor_rdt_zero", r, 32'd0);
        op(0, 32'h8000_0000, 32'h0, 4'hF, 1'b0, "oor_hi", r);
        op(0, 32'h000, 32'h0, 4'hF, 1'b0, "oor_low", r);
        chk("oor_low_value", r, 32'hCAFEF00D);

        // Wait states: read then an intervening write must not disturb rdt.
        op(1, 32'h40, 32'h5A5A0001, 4'hF, 1'b1, "ws_wr", r);
        op(1, 32'h40, 32'h0, 4'hF, 1'b0, "ws_rd", r);
        chk("ws_value", r, 32'h5A5A0001);
        op(1, 32'h44, 32'h77777777, 4'hF, 1'b1, "ws_wr2", r);
        chk("ws_rdt_hold", rdt_v[1], 32'h5A5A0001);

        // Abort: drop cyc one cycle after acceptance.
        op(1, 32'h30, 32'h0BADF00D, 4'hF, 1'b1, "abort_pre", r);
        @(negedge clk);
        adr_v[1] = 32'h30; dat_v[1] = 32'h12345678; sel_v[1] = 4'hF;
        we_v[1] = 1'b1; cyc_v[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc_v[1] = 1'b0;
        any = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            #1;
            any = any | ack_v[1] | err_v[1];
        end
        chk("abort_no_strobe", 32'(any), 32'd0);
        op(1, 32'h30, 32'h0, 4'hF, 1'b0, "abort_rd", r);
        chk("abort_value", r, 32'h0BADF00D);

        // Reset during WAIT of a write.
        op(1, 32'h50, 32'h55AA55AA, 4'hF, 1'b1, "rst_pre", r);
        op(1, 32'h50, 32'h0, 4'hF, 1'b0, "rst_prerd", r);
        @(negedge clk);
        adr_v[1] = 32'h50; dat_v[1] = 32'hFFFFFFFF; sel_v[1] = 4'hF;
        we_v[1] = 1'b1; cyc_v[1] = 1'b1;
        @(posedge clk);
        #2;
        rst3 = 1'b1;
        #1;
        chk("rst_rdt", rdt_v[1], 32'd0);
        chk("rst_ack", 32'(ack_v[1]), 32'd0);
        chk("rst_err", 32'(err_v[1]), 32'd0);
        @(negedge clk);
        cyc_v[1] = 1'b0;
        @(negedge clk);
        rst3 = 1'b0;
        exp_rdt[1] = 32'd0;
        op(1, 32'h50, 32'h0, 4'hF, 1'b0, "rst_rd", r);
        chk("rst_value", r, 32'h55AA55AA);

        // Randomized traffic on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 16; w++)
                op(d, 32'h100 + 32'(w * 4), $urandom, 4'hF, 1'b1, "rnd_pre", r);
            for (int n = 0; n < 60; n++) begin
                k = $urandom_range(0, 9);
                if (k == 0)      a = 32'h400 + 32'($urandom_range(0, 255) * 4);
                else if (k == 1) a = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
                else             a = 32'h100 + 32'($urandom_range(0, 15) * 4);
                op(d, a, $urandom, 4'($urandom), 1'($urandom), "rnd", r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serv_dbus_responder.md
# serv_dbus_responder

Wishbone-classic responder that serves the data bus emitted by the SERV core's buffer register and memory interface. It holds a byte-addressable local RAM and performs word reads and byte-lane-masked writes. It answers each request with a single-cycle acknowledge after a programmable number of wait states, and flags out-of-range addresses with an error strobe. It sits between the core's dbus port and the rest of the SoC as the core's default data memory and as a bench target for bus-timing stress.

## Interface
- DEPTH, 1024: RAM size in bytes; power of two, minimum 8.
- AW, $clog2(DEPTH): byte-address bits decoded.
- WAIT_STATES, 0: extra cycles between request acceptance and memory access, 0..15.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  reset; asynchronous and active-high; one clock, no other clock domains.
- i_wb_adr  in  32  byte address; bits [1:0] ignored (the initiator always drives them 00).
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte-lane enables; bit n covers [8n+7:8n].
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_cyc  in  1  request valid; held by the initiator until ack or err.
- o_wb_rdt  out  32  read data, registered.
- o_wb_ack  out  1  one-cycle completion strobe.
- o_wb_err  out  1  one-cycle error strobe; mutually exclusive with o_wb_ack.

## Operation
- The state machine has three states: IDLE, WAIT and RESP.
- **IDLE**
  - When i_wb_cyc=1, the block latches adr, dat, sel and we, and loads the wait counter with WAIT_STATES.
  - It moves to WAIT if WAIT_STATES>0, otherwise directly to RESP.
- **WAIT**
  - The counter decrements each cycle.
  - When the counter reaches 1 with i_wb_cyc still high, the block moves to RESP.
  - If i_wb_cyc falls in WAIT, the block aborts: it returns to IDLE with no write, no ack and no err.
- **Entering RESP** (the access cycle), decided on the latched fields:
  - Range check: latched adr[31:AW] must be zero; otherwise the access is an error.
  - Valid write: lanes with sel=1 are updated; other lanes keep their value. sel=0000 is legal and writes nothing.
  - Valid read: the word at adr[AW-1:2] is loaded into o_wb_rdt.
  - Error: no write occurs and o_wb_rdt is loaded with 0.
- **RESP**
  - The block asserts o_wb_ack for valid accesses, or o_wb_err for errors, for exactly one cycle, then returns to IDLE.
  - The responder ignores i_wb_cyc during RESP; it never accepts a new request in the RESP cycle.
- **Holding and memory contents**
  - o_wb_rdt holds its value until the next read or error response; writes do not change it.
  - RAM contents are not reset and are undefined until written.
  - Latched request fields are never re-sampled mid-transaction; changes on the bus inputs after acceptance are ignored.

## Timing
- Request accepted on clock edge T (i_wb_cyc=1 and IDLE): ack or err is high in cycle T+1+WAIT_STATES.
  - With WAIT_STATES=0, ack is high in the cycle after acceptance.
- Earliest back-to-back acceptance is edge T+2+WAIT_STATES, so throughput is one access per 2+WAIT_STATES cycles.
  - The initiator deasserts or re-drives i_wb_cyc in the cycle after ack.
- o_wb_rdt is valid in the same cycle as o_wb_ack and stable until the next read response.
- Write data is visible to a read accepted at the next edge after ack.
- Reset values: o_wb_ack=0, o_wb_err=0, o_wb_rdt=0, state IDLE, wait counter 0.
- Reset mid-transaction:
  - Asynchronous assertion forces IDLE immediately; no ack or err is produced.
  - A write that has not yet reached its access cycle is not performed.
  - A write already committed in RESP remains in the RAM.
- After reset release, the first request is accepted on the first edge with i_wb_cyc=1.
- i_wb_cyc=1 continuously with WAIT_STATES=0: one ack every 2 cycles, never two consecutive ack cycles.

## Test plan
- **Write/read basic (WAIT_STATES=0):** write 0xDEADBEEF to 0x10 with sel=1111, then read 0x10 -> each ack arrives 1 cycle after acceptance; the read returns 0xDEADBEEF.
- **Byte lanes:** preload 0x11223344 at 0x20, write 0xAABBCCDD with sel=0101, read back -> 0x11BB33DD; a further write with sel=0000 leaves 0x11BB33DD.
- **Wait states (WAIT_STATES=3):** read accepted at edge 5 -> ack high only in cycle 9; o_wb_rdt is valid in cycle 9 and still holds its value at cycle 15 after an intervening write.
- **Out of range (DEPTH=1024):** write to 0x400 then read 0x400 -> o_wb_err pulses one cycle each with no ack; o_wb_rdt=0; a read of 0x000 is unchanged.
- **Abort (WAIT_STATES=2):** write 0x12345678 to 0x30, dropping i_wb_cyc one cycle after acceptance -> no ack and no err; a later read of 0x30 returns the prior value.
- **Reset during WAIT:** pulse i_rst during the WAIT state of a write -> outputs are 0 immediately and the write is not performed; a later read of that address returns the prior value. A subsequent request is acked at the normal latency.
